// File: rtl/move_input_ctrl.sv
// Move input controller: synchronizes and debounces the board switches,
// validates a committed move against turn/occupancy, and issues either a
// one-cycle move_en or a one-cycle reject with a reason code.
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] SW,
  input  logic [8:0] occupied,
  input  logic       game_over,
  output logic       move_en,
  output logic [3:0] move_pos,
  output logic [1:0] move_player,
  output logic [1:0] turn,
  output logic       reject,
  output logic [1:0] err_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EVAL, ISSUE, WAIT_REL, LOCKED} state_t;

  logic [6:0]    sw_m_q, sw_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d, db_prev_q;
  logic          armed_q;
  logic [1:0]    settle_q;
  logic          commit_evt;

  state_t        state_q;
  logic [3:0]    cap_pos_q;
  logic [1:0]    cap_pl_q;
  logic          move_en_q, reject_q;
  logic [3:0]    move_pos_q;
  logic [1:0]    move_player_q, turn_q, err_q;

  // Debounce next state: flip the level after CNT_LAST+1 consecutive mismatches
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sw_s_q[6] != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and post-reset arming
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_m_q    <= '0;
      sw_s_q    <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
    end else begin
      sw_m_q    <= SW;
      sw_s_q    <= sw_m_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      // Arm only after a genuinely released switch has been seen post-reset,
      // so a commit held through reset release cannot fire a move.
      if (settle_q == 2'd2 && !sw_s_q[6] && !db_q) armed_q <= 1'b1;
    end
  end

  assign commit_evt = db_q & ~db_prev_q & armed_q;

  // Move FSM; pulses are registered on the EVAL exit so both outcomes share latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cap_pos_q     <= '0;
      cap_pl_q      <= '0;
      move_en_q     <= 1'b0;
      reject_q      <= 1'b0;
      move_pos_q    <= '0;
      move_player_q <= '0;
      turn_q        <= 2'b01;
      err_q         <= 2'b00;
    end else if (game_over) begin
      state_q   <= LOCKED;
      move_en_q <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      move_en_q <= 1'b0;
      reject_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit_evt) begin
            cap_pos_q <= sw_s_q[5:2];
            cap_pl_q  <= sw_s_q[1:0];
            state_q   <= EVAL;
          end
        end
        EVAL: begin
          if (cap_pos_q > 4'd8) begin
            reject_q <= 1'b1;
            err_q    <= 2'b01;
            state_q  <= WAIT_REL;
          end else if (cap_pl_q != turn_q) begin
            reject_q <= 1'b1;
            err_q    <= 2'b10;
            state_q  <= WAIT_REL;
          end else if (occupied[cap_pos_q]) begin
            reject_q <= 1'b1;
            err_q    <= 2'b11;
            state_q  <= WAIT_REL;
          end else begin
            move_en_q     <= 1'b1;
            move_pos_q    <= cap_pos_q;
            move_player_q <= cap_pl_q;
            err_q         <= 2'b00;
            turn_q        <= ~turn_q;
            state_q       <= ISSUE;
          end
        end
        ISSUE:    state_q <= WAIT_REL;
        WAIT_REL: if (!db_q) state_q <= IDLE;
        LOCKED:   state_q <= LOCKED;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign move_en     = move_en_q;
  assign reject      = reject_q;
  assign move_pos    = move_pos_q;
  assign move_player = move_player_q;
  assign turn        = turn_q;
  assign err_code    = err_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: directed scenarios plus random switch activity,
// every cycle checked against a behavioural model of the controller.
module tb_move_input_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] SW;
  logic [8:0] occupied;
  logic       game_over;
  logic       move_en, reject;
  logic [3:0] move_pos;
  logic [1:0] move_player, turn, err_code;

  move_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .SW(SW), .occupied(occupied), .game_over(game_over),
    .move_en(move_en), .move_pos(move_pos), .move_player(move_player),
    .turn(turn), .reject(reject), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;
  int rj_cnt = 0;

  // Reference model state
  logic [6:0]    m_s1, m_s2;
  bit            m_v1, m_v2;
  logic [DB-1:0] m_hist;
  bit            m_db, m_armed, m_evt;
  int            m_mode;   // 0 idle, 1 eval, 2 issue, 3 wait release, 4 locked
  logic [3:0]    m_cp;
  logic [1:0]    m_cpl;
  bit            e_en, e_rj;
  logic [3:0]    e_pos;
  logic [1:0]    e_pl, e_turn, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_v1 = 0; m_v2 = 0; m_hist = '0;
    m_db = 0; m_armed = 0; m_evt = 0; m_mode = 0; m_cp = '0; m_cpl = '0;
    e_en = 0; e_rj = 0; e_pos = '0; e_pl = '0; e_turn = 2'b01; e_err = 2'b00;
  endtask

  task automatic refuse(input logic [1:0] code);
    e_rj = 1; e_err = code; m_mode = 3;
  endtask

  // One rising edge of the model, using the inputs present at that edge
  task automatic model_edge();
    logic [6:0] smp;
    bit old_db, old_evt, old_armed, all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    smp = m_s2; old_db = m_db; old_evt = m_evt; old_armed = m_armed;
    // Level flips once the last DB synchronized samples all disagree with it
    m_hist = {m_hist[DB-2:0], smp[6]};
    all_diff = 1;
    for (int i = 0; i < DB; i++) if (m_hist[i] == old_db) all_diff = 0;
    if (all_diff) m_db = !old_db;
    m_evt = m_db && !old_db && old_armed;
    if (m_v2 && !smp[6] && !old_db) m_armed = 1;
    e_en = 0; e_rj = 0;
    if (game_over) m_mode = 4;
    else begin
      case (m_mode)
        0: if (old_evt) begin m_cp = smp[5:2]; m_cpl = smp[1:0]; m_mode = 1; end
        1: begin
          if (m_cp > 8)              refuse(2'b01);
          else if (m_cpl != e_turn)  refuse(2'b10);
          else if (occupied[m_cp])   refuse(2'b11);
          else begin
            e_en = 1; e_pos = m_cp; e_pl = m_cpl; e_err = 2'b00;
            e_turn = (e_turn == 2'b01) ? 2'b10 : 2'b01;
            m_mode = 2;
          end
        end
        2: m_mode = 3;
        3: if (!old_db) m_mode = 0;
        default: m_mode = 4;
      endcase
    end
    m_s2 = m_s1; m_v2 = m_v1; m_s1 = SW; m_v1 = 1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("move_en", move_en, e_en);
      chk("reject", reject, e_rj);
      chk("move_pos", move_pos, e_pos);
      chk("move_player", move_player, e_pl);
      chk("turn", turn, e_turn);
      chk("err_code", err_code, e_err);
      chk("excl", move_en & reject, 0);
      en_cnt += int'(move_en);
      rj_cnt += int'(reject);
    end
  endtask

  task automatic press(input logic [3:0] idx, input logic [1:0] pl, input int hold);
    SW = {1'b1, idx, pl};
    step(hold);
    SW[6] = 1'b0;
    step(14);
  endtask

  initial begin
    int e0, r0, k;
    model_reset();
    reset = 1; SW = '0; occupied = '0; game_over = 0;
    step(3);
    chk("rst_turn", turn, 2'b01);
    chk("rst_move_en", move_en, 0);
    chk("rst_err", err_code, 0);
    chk("rst_pos", move_pos, 0);
    reset = 0;
    step(4);

    // Legal move by P1 at cell 4
    e0 = en_cnt;
    press(4'd4, 2'b01, 12);
    chk("legal_cnt", en_cnt - e0, 1);
    chk("legal_pos", move_pos, 4);
    chk("legal_pl", move_player, 2'b01);
    chk("legal_turn", turn, 2'b10);

    // Bouncing commit never settles
    e0 = en_cnt; r0 = rj_cnt;
    SW = {1'b0, 4'd5, 2'b10};
    for (int i = 0; i < 5; i++) begin
      SW[6] = 1'b1; step(2);
      SW[6] = 1'b0; step(2);
    end
    step(10);
    chk("bounce_pulses", (en_cnt - e0) + (rj_cnt - r0), 0);

    // Wrong player
    r0 = rj_cnt;
    press(4'd2, 2'b01, 12);
    chk("wrongpl_rj", rj_cnt - r0, 1);
    chk("wrongpl_err", err_code, 2'b10);
    chk("wrongpl_turn", turn, 2'b10);

    // Occupied cell, then bad index
    occupied = 9'h010;
    press(4'd4, 2'b10, 12);
    chk("occ_err", err_code, 2'b11);
    press(4'd9, 2'b10, 12);
    chk("badidx_err", err_code, 2'b01);

    // Commit held for 100 cycles gives one move
    occupied = '0;
    e0 = en_cnt;
    press(4'd0, 2'b10, 100);
    chk("held_cnt", en_cnt - e0, 1);
    chk("held_turn", turn, 2'b01);

    // Reset during EVAL suppresses the pulse; held commit through reset is ignored
    e0 = en_cnt; r0 = rj_cnt;
    SW = {1'b1, 4'd1, 2'b01};
    k = 0;
    while (m_mode != 1 && k < 40) begin step(1); k++; end
    chk("eval_reached", k < 40, 1);
    reset = 1; step(2); reset = 0;
    step(30);
    chk("rst_suppress", (en_cnt - e0) + (rj_cnt - r0), 0);
    SW[6] = 1'b0; step(14);
    press(4'd1, 2'b01, 12);
    chk("rearm_cnt", en_cnt - e0, 1);

    // game_over locks the block until reset
    e0 = en_cnt; r0 = rj_cnt;
    game_over = 1; step(2); game_over = 0;
    press(4'd3, 2'b10, 12);
    chk("locked_pulses", (en_cnt - e0) + (rj_cnt - r0), 0);
    reset = 1; step(2); reset = 0; step(3);
    chk("unlock_turn", turn, 2'b01);
    press(4'd3, 2'b01, 12);
    chk("unlock_cnt", en_cnt - e0, 1);

    // Random switch activity
    for (int it = 0; it < 400; it++) begin
      SW = 7'($urandom);
      occupied = 9'($urandom);
      reset = ($urandom_range(0, 29) == 0);
      game_over = ($urandom_range(0, 59) == 0);
      step($urandom_range(1, 12));
      reset = 0; game_over = 0;
    end
    step(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/move_input_ctrl.md
MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000; number of consecutive stable clk cycles required before the debounced commit level changes; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 SW  input  7  raw board switches, asynchronous: SW[6] commit, SW[5:2] cell index 0..8, SW[1:0] player (01 = P1, 10 = P2).
REQ-005 occupied  input  9  bit i high means cell i already holds a mark; supplied by the position-register stage.
REQ-006 game_over  input  1  high when a win or a full board has been declared.
REQ-007 move_en  output  1  one-cycle pulse; a legal move is presented on move_pos/move_player.
REQ-008 move_pos  output  4  cell index of the accepted move; valid while move_en is high.
REQ-009 move_player  output  2  player of the accepted move (01/10); valid while move_en is high.
REQ-010 turn  output  2  player expected to move next (01/10).
REQ-011 reject  output  1  one-cycle pulse; the committed move was refused.
REQ-012 err_code  output  2  reason for the last refusal: 00 none, 01 bad index, 10 wrong player, 11 cell occupied.

Function
REQ-013 All SW bits shall pass through a two-flop synchronizer before any other use.
REQ-014 The debounced commit level shall change only after synchronized SW[6] has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce shall restart the count at zero.
REQ-015 A commit event shall be a 0->1 transition of the debounced commit level.
REQ-016 States shall be IDLE, EVAL, ISSUE, WAIT_REL and LOCKED.
REQ-017 IDLE: on a commit event, the block shall capture synchronized SW[5:2] and SW[1:0] and enter EVAL on the next edge.
REQ-018 EVAL: checks shall be applied in priority order: index > 8 gives err 01; player != turn (including 00 or 11) gives err 10; occupied[index] gives err 11.
REQ-019 On a failed check in EVAL, the block shall assert reject for exactly one cycle, load err_code, and enter WAIT_REL.
REQ-020 On passing all checks in EVAL, the block shall enter ISSUE.
REQ-021 ISSUE: move_en shall be high for exactly one cycle with the captured index and player; err_code shall be set to 00; turn shall toggle between 01 and 10; the block then enters WAIT_REL.
REQ-022 Latency: a commit event on edge T shall produce move_en or reject high in the cycle following edge T+2.
REQ-023 WAIT_REL: the block shall return to IDLE when the debounced commit level is 0; a held commit shall never produce a second move.
REQ-024 While move_en is low, move_pos and move_player shall hold their last accepted values.
REQ-025 game_over high in any state shall force LOCKED on the next edge, with no move_en or reject issued that cycle; LOCKED shall be left only via reset.
REQ-026 Switch changes after capture shall not affect a move already in EVAL or ISSUE.
REQ-027 move_en and reject shall never be high in the same cycle.

Reset
REQ-028 While reset is high, the block shall enter IDLE.
REQ-029 While reset is high, the synchronizers, debounce counter and debounced level shall clear to 0.
REQ-030 Reset values: move_en=0, reject=0, move_pos=0, move_player=00, err_code=00, turn=01.
REQ-031 Reset asserted mid-EVAL or mid-ISSUE shall suppress the pending pulse.
REQ-032 A commit switch held high through reset release shall produce no move until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 SW=1_0100_01 with occupied=0 and turn=01 -> one move_en, move_pos=4, move_player=01, turn becomes 10.
REQ-034 SW[6] toggling every 2 cycles for 20 cycles -> no move_en and no reject.
REQ-035 Turn=10 and player 01 committed -> reject pulse, err_code=10, turn unchanged.
REQ-036 occupied[4]=1 and cell 4 committed -> reject, err_code=11; index 9 committed -> reject, err_code=01.
REQ-037 Commit held high for 100 cycles -> exactly one move_en.
REQ-038 game_over asserted, then a legal commit -> no pulses; reset then restores turn=01 and IDLE.
